sap_obi_slave_cut: RTL and testbench

SAP_OBI_SLAVE_CUT -- requirements
Module: sap_obi_slave_cut

---
 rtl/sap_pkg.sv | 22 ++
 rtl/sap_obi_cut_fifo.sv | 61 ++++++
 rtl/sap_obi_slave_cut.sv | 117 +++++++++++
 tb/tb_sap_obi_slave_cut.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared types and defaults for the SAP OBI slave-side register cut.
package sap_pkg;

  localparam int SAP_OBI_CUT_DEPTH_DEFAULT   = 2;
  localparam int SAP_OBI_CUT_MAX_OUT_DEFAULT = 4;
  localparam int SAP_OBI_CUT_PAYLOAD_W       = 69;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sap_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } sap_obi_resp_t;

endpackage

// File: rtl/sap_obi_cut_fifo.sv
// Request buffer: DEPTH-entry FIFO with pointers wrapping modulo DEPTH, no bypass.
module sap_obi_cut_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sap_obi_slave_cut.sv
// OBI cut between a crossbar slave port and a peripheral: buffered requests, capped outstanding.
// Define SAP_OBI_CUT_RESP_REG_EN to register the response path (1-cycle latency).
module sap_obi_slave_cut
  import sap_pkg::*;
#(
  parameter type obi_req_t       = sap_obi_req_t,
  parameter type obi_resp_t      = sap_obi_resp_t,
  parameter int  DEPTH           = SAP_OBI_CUT_DEPTH_DEFAULT,
  parameter int  MAX_OUTSTANDING = SAP_OBI_CUT_MAX_OUT_DEFAULT,
  localparam int OW              = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  obi_req_t      master_req_i,
  output obi_resp_t     master_resp_o,
  output obi_req_t      slave_req_o,
  input  obi_resp_t     slave_resp_i,
  output logic [OW-1:0] outstanding_o,
  output logic          idle_o,
  output logic          err_o
);

  localparam int W  = SAP_OBI_CUT_PAYLOAD_W;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  fifo_wdata, fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic          gnt, up_hs, dn_hs, rsp_ok, dec;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic          err_q, err_d;

  // Grant is purely local so the peripheral's gnt never reaches the crossbar combinationally.
  assign gnt        = (fifo_cnt < CW'(DEPTH)) && (outstanding_q < OW'(MAX_OUTSTANDING));
  assign up_hs      = master_req_i.req && gnt;
  assign dn_hs      = !fifo_empty && slave_resp_i.gnt;
  assign fifo_wdata = {master_req_i.we, master_req_i.be, master_req_i.addr, master_req_i.wdata};

  sap_obi_cut_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (up_hs),
    .pop_i   (dn_hs),
    .data_i  (fifo_wdata),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    slave_req_o       = '0;
    slave_req_o.req   = !fifo_empty;
    {slave_req_o.we, slave_req_o.be, slave_req_o.addr, slave_req_o.wdata} = fifo_rdata;
  end

`ifdef SAP_OBI_CUT_RESP_REG_EN
  logic        rvalid_q;
  logic [31:0] rdata_q;

  // A registered rvalid still counts as outstanding until issued, so exclude it here.
  assign rsp_ok = slave_resp_i.rvalid && (outstanding_q > OW'(rvalid_q));
  assign dec    = rvalid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rsp_ok;
      rdata_q  <= rsp_ok ? slave_resp_i.rdata : '0;
    end
  end

  always_comb begin
    master_resp_o        = '0;
    master_resp_o.gnt    = gnt;
    master_resp_o.rvalid = rvalid_q;
    master_resp_o.rdata  = rdata_q;
  end
`else
  assign rsp_ok = slave_resp_i.rvalid && (outstanding_q != '0);
  assign dec    = rsp_ok;

  always_comb begin
    master_resp_o        = '0;
    master_resp_o.gnt    = gnt;
    master_resp_o.rvalid = rsp_ok;
    master_resp_o.rdata  = rsp_ok ? slave_resp_i.rdata : '0;
  end
`endif

  always_comb begin
    outstanding_d = outstanding_q;
    if (up_hs && !dec)      outstanding_d = outstanding_q + 1'b1;
    else if (!up_hs && dec) outstanding_d = outstanding_q - 1'b1;
    err_d = err_q | (slave_resp_i.rvalid && !rsp_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign outstanding_o = outstanding_q;
  assign idle_o        = (outstanding_q == '0);
  assign err_o         = err_q;

endmodule

// File: tb/tb_sap_obi_slave_cut.sv
// Directed bench for sap_obi_slave_cut (DEPTH=2, MAX_OUTSTANDING=4).
module tb_sap_obi_slave_cut;
  import sap_pkg::*;

  logic          clk, rst_n;
  sap_obi_req_t  mreq, sreq;
  sap_obi_resp_t mresp, sresp;
  logic [2:0]    outstanding;
  logic          idle, err;
  int            checks, errors;

  sap_obi_slave_cut #(
    .obi_req_t       (sap_obi_req_t),
    .obi_resp_t      (sap_obi_resp_t),
    .DEPTH           (2),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .master_req_i  (mreq),
    .master_resp_o (mresp),
    .slave_req_o   (sreq),
    .slave_resp_i  (sresp),
    .outstanding_o (outstanding),
    .idle_o        (idle),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    mreq.req   = 1'b1;
    mreq.we    = we;
    mreq.be    = 4'hF;
    mreq.addr  = addr;
    mreq.wdata = wdata;
  endtask

  // One-cycle slave rvalid pulse; returns once the counter has absorbed it.
  task automatic respond(input logic [31:0] data);
    sresp.rvalid = 1'b1;
    sresp.rdata  = data;
    cyc();
    sresp.rvalid = 1'b0;
    sresp.rdata  = '0;
`ifdef SAP_OBI_CUT_RESP_REG_EN
    cyc();
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (sreq.req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", sreq.req); end
    checks++; if (mresp.gnt !== 1'b1) begin errors++; $display("FAIL reset_gnt got %0b want 1", mresp.gnt); end
    checks++; if (mresp.rvalid !== 1'b0 || mresp.rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp got %0b/%h want 0/0", mresp.rvalid, mresp.rdata); end
    checks++; if (outstanding !== 3'd0 || idle !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL reset_status got out=%0d idle=%0b err=%0b want 0/1/0", outstanding, idle, err); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_write();
    sresp.gnt = 1'b1;
    drive_req(1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
    checks++; if (mresp.gnt !== 1'b1) begin errors++; $display("FAIL single_gnt got %0b want 1", mresp.gnt); end
    checks++; if (sreq.req !== 1'b0) begin errors++; $display("FAIL single_nobypass got %0b want 0", sreq.req); end
    cyc();
    mreq.req = 1'b0;
    checks++; if (sreq.req !== 1'b1 || sreq.we !== 1'b1 || sreq.be !== 4'hF) begin errors++; $display("FAIL single_req got req=%0b we=%0b be=%h want 1/1/f", sreq.req, sreq.we, sreq.be); end
    checks++; if (sreq.addr !== 32'h1000_0004 || sreq.wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_payload got %h/%h want 10000004/deadbeef", sreq.addr, sreq.wdata); end
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_out1 got %0d want 1", outstanding); end
    cyc();
    checks++; if (sreq.req !== 1'b0 || outstanding !== 3'd1) begin errors++; $display("FAIL single_issued got req=%0b out=%0d want 0/1", sreq.req, outstanding); end
    respond(32'h0);
    checks++; if (outstanding !== 3'd0 || idle !== 1'b1) begin errors++; $display("FAIL single_out0 got out=%0d idle=%0b want 0/1", outstanding, idle); end
  endtask

  task automatic test_backpressure();
    sresp.gnt = 1'b0;
    drive_req(1'b0, 32'h0000_0A00, 32'h0);
    checks++; if (mresp.gnt !== 1'b1) begin errors++; $display("FAIL bp_gnt_a got %0b want 1", mresp.gnt); end
    cyc();
    drive_req(1'b0, 32'h0000_0B00, 32'h0);
    checks++; if (mresp.gnt !== 1'b1) begin errors++; $display("FAIL bp_gnt_b got %0b want 1", mresp.gnt); end
    cyc();
    drive_req(1'b0, 32'h0000_0C00, 32'h0);
    checks++; if (mresp.gnt !== 1'b0) begin errors++; $display("FAIL bp_gnt_c got %0b want 0", mresp.gnt); end
    cyc();
    mreq.req = 1'b0;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL bp_out got %0d want 2", outstanding); end
    checks++; if (sreq.req !== 1'b1 || sreq.addr !== 32'h0000_0A00) begin errors++; $display("FAIL bp_head_a got %0b/%h want 1/00000a00", sreq.req, sreq.addr); end
    sresp.gnt = 1'b1;
    cyc();
    checks++; if (sreq.req !== 1'b1 || sreq.addr !== 32'h0000_0B00) begin errors++; $display("FAIL bp_head_b got %0b/%h want 1/00000b00", sreq.req, sreq.addr); end
    cyc();
    checks++; if (sreq.req !== 1'b0) begin errors++; $display("FAIL bp_drained got %0b want 0", sreq.req); end
    respond(32'h1);
    respond(32'h2);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL bp_idle got %0b want 1", idle); end
  endtask

  task automatic test_max_outstanding();
    sresp.gnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b0, 32'h2000_0000 + 32'(i * 4), 32'h0);
      checks++;
      if (mresp.gnt !== (i < 4)) begin errors++; $display("FAIL maxout_gnt%0d got %0b want %0b", i, mresp.gnt, (i < 4)); end
      if (i < 4) cyc();
    end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL maxout_full got %0d want 4", outstanding); end
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'h0;
    cyc();
    sresp.rvalid = 1'b0;
`ifdef SAP_OBI_CUT_RESP_REG_EN
    checks++; if (mresp.gnt !== 1'b0) begin errors++; $display("FAIL maxout_regwait got %0b want 0", mresp.gnt); end
    cyc();
`endif
    checks++; if (mresp.gnt !== 1'b1 || outstanding !== 3'd3) begin errors++; $display("FAIL maxout_regrant got gnt=%0b out=%0d want 1/3", mresp.gnt, outstanding); end
    cyc();
    mreq.req = 1'b0;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL maxout_fifth got %0d want 4", outstanding); end
    cyc();
    for (int i = 0; i < 4; i++) respond(32'(i));
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL maxout_idle got %0b want 1", idle); end
  endtask

  task automatic test_resp_latency();
    sresp.gnt = 1'b1;
    drive_req(1'b0, 32'h3000_0000, 32'h0);
    cyc();
    mreq.req = 1'b0;
    cyc();
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'hA5A5_0001;
    #1;
`ifdef SAP_OBI_CUT_RESP_REG_EN
    checks++; if (mresp.rvalid !== 1'b0) begin errors++; $display("FAIL lat_n got %0b want 0", mresp.rvalid); end
    cyc();
    sresp.rvalid = 1'b0;
    sresp.rdata  = '0;
    checks++; if (mresp.rvalid !== 1'b1 || mresp.rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL lat_n1 got %0b/%h want 1/a5a50001", mresp.rvalid, mresp.rdata); end
    cyc();
`else
    checks++; if (mresp.rvalid !== 1'b1 || mresp.rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL lat_n got %0b/%h want 1/a5a50001", mresp.rvalid, mresp.rdata); end
    cyc();
    sresp.rvalid = 1'b0;
    sresp.rdata  = '0;
`endif
    checks++; if (mresp.rvalid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL lat_done got rvalid=%0b idle=%0b want 0/1", mresp.rvalid, idle); end
  endtask

  task automatic test_unexpected();
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'h1234_5678;
    #1;
    checks++; if (mresp.rvalid !== 1'b0) begin errors++; $display("FAIL unexp_fwd got %0b want 0", mresp.rvalid); end
    cyc();
    sresp.rvalid = 1'b0;
    sresp.rdata  = '0;
    checks++; if (err !== 1'b1 || outstanding !== 3'd0 || mresp.rvalid !== 1'b0) begin errors++; $display("FAIL unexp_err got err=%0b out=%0d rvalid=%0b want 1/0/0", err, outstanding, mresp.rvalid); end
    repeat (3) cyc();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL unexp_sticky got %0b want 1", err); end
  endtask

  task automatic test_reset_midop();
    sresp.gnt = 1'b1;
    drive_req(1'b1, 32'h4000_0000, 32'h1);
    cyc();
    drive_req(1'b1, 32'h4000_0004, 32'h2);
    cyc();
    sresp.gnt = 1'b0;
    drive_req(1'b1, 32'h4000_0008, 32'h3);
    cyc();
    mreq.req = 1'b0;
    checks++; if (outstanding !== 3'd3 || sreq.addr !== 32'h4000_0004) begin errors++; $display("FAIL mid_setup got out=%0d head=%h want 3/40000004", outstanding, sreq.addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sreq.req !== 1'b0 || mresp.gnt !== 1'b1 || mresp.rvalid !== 1'b0 || mresp.rdata !== 32'h0) begin errors++; $display("FAIL mid_rst_if got req=%0b gnt=%0b rvalid=%0b rdata=%h want 0/1/0/0", sreq.req, mresp.gnt, mresp.rvalid, mresp.rdata); end
    checks++; if (outstanding !== 3'd0 || idle !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL mid_rst_status got out=%0d idle=%0b err=%0b want 0/1/0", outstanding, idle, err); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    sresp.rvalid = 1'b1;
    sresp.rdata  = 32'hBAD0_0001;
    #1;
    checks++; if (mresp.rvalid !== 1'b0) begin errors++; $display("FAIL mid_stale_fwd got %0b want 0", mresp.rvalid); end
    cyc();
    sresp.rvalid = 1'b0;
    checks++; if (err !== 1'b1 || outstanding !== 3'd0) begin errors++; $display("FAIL mid_stale_err got err=%0b out=%0d want 1/0", err, outstanding); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mreq   = '0;
    sresp  = '0;
    test_reset();
    test_single_write();
    test_backpressure();
    test_max_outstanding();
    test_resp_latency();
    test_unexpected();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
